conv3x3_mac: RTL and testbench

CONV3X3_MAC -- requirements
Module: conv3x3_mac

---
 rtl/conv_pkg.sv | 16 +
 rtl/conv3x3_mac_if.sv | 22 ++
 rtl/sat_round.sv | 46 ++++
 rtl/conv3x3_mac.sv | 115 +++++++++++
 tb/tb_conv3x3_mac.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared defaults, tap count and controller state encoding for conv3x3_mac.
package conv_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 10;
    localparam int DEF_ACC_WIDTH  = 36;
    localparam int TAPS           = 9;
    localparam int TAP_WIDTH      = $clog2(TAPS);

    typedef enum logic [1:0] {
        ACC,
        FIN,
        OUT
    } state_t;

endpackage

// File: rtl/conv3x3_mac_if.sv
// Pixel-in / result-out handshake bundle for conv3x3_mac.
// master = upstream pixel source and downstream result sink; slave = the MAC.
interface conv3x3_mac_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] pix_in;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [DATA_WIDTH-1:0] res_out;
    logic                  res_valid;
    logic                  res_ready;

    modport master (
        output pix_in, pix_valid, res_ready,
        input  pix_ready, res_out, res_valid
    );

    modport slave (
        input  pix_in, pix_valid, res_ready,
        output pix_ready, res_out, res_valid
    );
endinterface

// File: rtl/sat_round.sv
// Combinational output stage: round half up, drop the fraction, saturate to
// DATA_WIDTH signed. Defining CONV3X3_RELU_EN also clamps negatives to zero.
module sat_round
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]  sum,
    output logic        [DATA_WIDTH-1:0] res
);
    // One guard bit so adding the rounding constant cannot overflow.
    localparam int RW = ACC_WIDTH + 1;

    logic signed [RW-1:0] half;
    logic signed [RW-1:0] rounded;
    logic signed [RW-1:0] shifted;
    logic signed [RW-1:0] max_v;
    logic signed [RW-1:0] min_v;

    // Round, shift and clamp to the representable output range.
    always_comb begin
        half                    = '0;
        half[FRAC_BITS-1]       = 1'b1;
        max_v                   = '0;
        max_v[DATA_WIDTH-2:0]   = '1;
        min_v                   = '1;
        min_v[DATA_WIDTH-2:0]   = '0;
        rounded                 = {sum[ACC_WIDTH-1], sum} + half;
        shifted                 = rounded >>> FRAC_BITS;
        if (shifted > max_v) begin
            res = max_v[DATA_WIDTH-1:0];
        end else if (shifted < min_v) begin
            res = min_v[DATA_WIDTH-1:0];
        end else begin
            res = shifted[DATA_WIDTH-1:0];
        end
`ifdef CONV3X3_RELU_EN
        if (res[DATA_WIDTH-1]) begin
            res = '0;
        end
`else
`endif
    end
endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 convolution multiply-accumulate: takes 9 window pixels in raster order,
// adds bias, rounds/saturates and presents one Q6.10 result per window.
// Optional feature macro: CONV3X3_RELU_EN (ReLU on the result, in sat_round).
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] w0,
    input  logic [DATA_WIDTH-1:0] w1,
    input  logic [DATA_WIDTH-1:0] w2,
    input  logic [DATA_WIDTH-1:0] w3,
    input  logic [DATA_WIDTH-1:0] w4,
    input  logic [DATA_WIDTH-1:0] w5,
    input  logic [DATA_WIDTH-1:0] w6,
    input  logic [DATA_WIDTH-1:0] w7,
    input  logic [DATA_WIDTH-1:0] w8,
    input  logic [DATA_WIDTH-1:0] bias,
    conv3x3_mac_if.slave          stream,
    output logic                  busy
);
    localparam int PW = 2 * DATA_WIDTH;

    state_t                  state;
    state_t                  state_next;
    logic [TAP_WIDTH-1:0]    tap;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0]   wsel;
    logic signed [PW-1:0]    prod;
    logic [DATA_WIDTH-1:0]   res_next;
    logic [DATA_WIDTH-1:0]   res_q;
    logic                    accept;
    logic                    res_take;

    assign accept   = stream.pix_valid && stream.pix_ready;
    assign res_take = stream.res_valid && stream.res_ready;
    assign stream.res_out = res_q;

    // Weight for the current tap; weights are read live, never stored.
    always_comb begin
        unique case (tap)
            4'd0:    wsel = w0;
            4'd1:    wsel = w1;
            4'd2:    wsel = w2;
            4'd3:    wsel = w3;
            4'd4:    wsel = w4;
            4'd5:    wsel = w5;
            4'd6:    wsel = w6;
            4'd7:    wsel = w7;
            4'd8:    wsel = w8;
            default: wsel = '0;
        endcase
        prod = $signed(stream.pix_in) * $signed(wsel);
        sum  = acc + {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){bias[DATA_WIDTH-1]}},
                      bias, {FRAC_BITS{1'b0}}};
    end

    sat_round #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat_round (
        .sum (sum),
        .res (res_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            ACC: if (accept && tap == TAP_WIDTH'(TAPS - 1)) state_next = FIN;
            FIN: state_next = OUT;
            OUT: if (res_take) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        stream.pix_ready = (state == ACC);
        stream.res_valid = (state == OUT);
        busy             = !(state == ACC && tap == '0);
    end

    // Accumulator, tap counter and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap   <= '0;
            acc   <= '0;
            res_q <= '0;
        end else begin
            if (state == ACC && accept) begin
                acc <= acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
                tap <= (tap == TAP_WIDTH'(TAPS - 1)) ? '0 : tap + 1'b1;
            end
            if (state == FIN) begin
                res_q <= res_next;
            end
            if (state == OUT && res_take) begin
                acc <= '0;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed-vector bench for conv3x3_mac with hand-computed expected results.
module tb_conv3x3_mac;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] w [9];
    logic [15:0] bias;
    logic [15:0] pix_vec [9];
    logic        busy;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    conv3x3_mac_if #(.DATA_WIDTH(16)) bus ();

    conv3x3_mac #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (10),
        .ACC_WIDTH  (36)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .w0     (w[0]),
        .w1     (w[1]),
        .w2     (w[2]),
        .w3     (w[3]),
        .w4     (w[4]),
        .w5     (w[5]),
        .w6     (w[6]),
        .w7     (w[7]),
        .w8     (w[8]),
        .bias   (bias),
        .stream (bus.slave),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef CONV3X3_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    task automatic set_all(input logic [15:0] wv, input logic [15:0] pv, input logic [15:0] bv);
        for (int k = 0; k < 9; k++) begin
            w[k]       = wv;
            pix_vec[k] = pv;
        end
        bias = bv;
    endtask

    task automatic feed(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            if (gap > 0 && (k % 2) == 1) begin
                repeat (gap) begin
                    bus.pix_valid = 1'b0;
                    bus.pix_in    = 16'hDEAD;
                    @(posedge clk); #1;
                end
            end
            bus.pix_valid = 1'b1;
            bus.pix_in    = pix_vec[k];
            @(posedge clk); #1;
        end
        bus.pix_valid = 1'b0;
        bus.pix_in    = 16'hBEEF;
    endtask

    task automatic run_window(input string tag, input logic [15:0] exp, input int gap, input int stall);
        int n;
        feed(9, gap);
        check({tag, "_fin_valid"}, 32'(bus.res_valid), 32'd0);
        n = 0;
        while (!bus.res_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd1);
        check({tag, "_res"}, 32'(bus.res_out), 32'(exp));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check({tag, "_stall_res"}, 32'(bus.res_out), 32'(exp));
            check({tag, "_stall_ready"}, 32'(bus.pix_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_ready"}, 32'(bus.pix_ready), 32'd1);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rst_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_rst_res"}, 32'(bus.res_out), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check({tag, "_rst_ready"}, 32'(bus.pix_ready), 32'd1);
    endtask

    initial begin
        bus.pix_in    = '0;
        bus.pix_valid = 1'b0;
        bus.res_ready = 1'b0;
        set_all(16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_valid", 32'(bus.res_valid), 32'd0);
        check("reset_res", 32'(bus.res_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(bus.pix_ready), 32'd1);

        set_all(16'h0400, 16'h0400, 16'h0000);
        run_window("unity", 16'h2400, 0, 0);

        set_all(16'h7FFF, 16'h7FFF, 16'h0000);
        run_window("sat_pos", 16'h7FFF, 0, 0);

        set_all(16'h7FFF, 16'h8000, 16'h0000);
        run_window("sat_neg", relu(16'h8000), 0, 0);

        set_all(16'h0400, 16'hFC00, 16'h0000);
        run_window("neg_nine", relu(16'hDC00), 0, 0);

        set_all(16'h0000, 16'h1234, 16'h0200);
        run_window("bias_only", 16'h0200, 0, 0);

        set_all(16'h0000, 16'h0000, 16'h0000);
        w[0] = 16'h0001; pix_vec[0] = 16'h0200;
        run_window("round_up", 16'h0001, 0, 0);
        pix_vec[0] = 16'hFE00;
        run_window("round_neg_half", 16'h0000, 0, 0);
        pix_vec[0] = 16'hFDFF;
        run_window("round_neg_below", relu(16'hFFFF), 0, 0);

        // w_k = k.0, pix_k = (k+1)/16 -> sum k(k+1)/16 = 15.0; tap order matters
        for (int k = 0; k < 9; k++) begin
            w[k]       = 16'(k * 16'h0400);
            pix_vec[k] = 16'((k + 1) * 16'h0040);
        end
        bias = 16'h0000;
        run_window("tap_order", 16'h3C00, 0, 0);
        run_window("tap_order_gaps", 16'h3C00, 2, 0);
        run_window("out_stall", 16'h3C00, 0, 5);

        set_all(16'h0400, 16'h0400, 16'h0000);
        feed(4, 0);
        check("mid_busy", 32'(busy), 32'd1);
        pulse_reset("mid");
        run_window("after_mid_rst", 16'h2400, 0, 0);

        feed(9, 0);
        repeat (3) @(posedge clk);
        #1;
        check("pending_valid", 32'(bus.res_valid), 32'd1);
        pulse_reset("pending");
        run_window("after_out_rst", 16'h2400, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
